// File: rtl/sprite_pkg.sv
// Shared types and defaults for the bouncing-sprite renderer.
// Also holds the per-axis bounce rule used by the motion block.
package sprite_pkg;

    typedef logic [11:0] rgb_t;

    localparam rgb_t KEY_COLOR = 12'hF0F;
    localparam rgb_t BLACK     = 12'h000;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } motion_e;

    typedef struct packed {
        logic [9:0] pos;
        dir_e       dir;
        logic       bounce;
    } axis_t;

    // One motion step on a single axis, clamping at 0 and lim.
    function automatic axis_t axis_step(
        input logic [9:0] pos,
        input dir_e       dir,
        input logic [9:0] step,
        input logic [9:0] lim
    );
        axis_t r;
        r.pos    = pos;
        r.dir    = dir;
        r.bounce = 1'b0;
        if (dir == DIR_POS) begin
            if (({1'b0, pos} + {1'b0, step}) >= {1'b0, lim}) begin
                r.pos    = lim;
                r.dir    = DIR_NEG;
                r.bounce = 1'b1;
            end else begin
                r.pos = pos + step;
            end
        end else begin
            if (pos <= step) begin
                r.pos    = '0;
                r.dir    = DIR_POS;
                r.bounce = 1'b1;
            end else begin
                r.pos = pos - step;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_bounce_engine_if.sv
// Scan-in / ROM / pixel-out bundle of the sprite renderer.
// master = timing generator + ROM side, slave = renderer.
interface sprite_bounce_engine_if #(
    parameter int ADDR_W = 14
);
    import sprite_pkg::*;

    logic              valid;
    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic              pause;
    rgb_t              bg_color;
    logic [ADDR_W-1:0] rom_addr;
    rgb_t              rom_data;
    rgb_t              vga_data;
    logic [9:0]        spr_x;
    logic [9:0]        spr_y;
    logic              edge_hit;
    logic              corner_hit;
    logic [15:0]       bounce_cnt;

    modport master (
        output valid, h_cnt, v_cnt, pause, bg_color, rom_data,
        input  rom_addr, vga_data, spr_x, spr_y,
        input  edge_hit, corner_hit, bounce_cnt
    );

    modport slave (
        input  valid, h_cnt, v_cnt, pause, bg_color, rom_data,
        output rom_addr, vga_data, spr_x, spr_y,
        output edge_hit, corner_hit, bounce_cnt
    );

endinterface

// File: rtl/sprite_motion.sv
// Frame tick, divider, RUN/HOLD control and bounce logic.
// Position only changes on the blanking tick, so no tearing.
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int SPR_W     = 100,
    parameter int SPR_H     = 100,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 2,
    parameter int START_X   = 430,
    parameter int START_Y   = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt_i,
    input  logic [9:0]  v_cnt_i,
    input  logic        pause_i,
    output logic [9:0]  spr_x_o,
    output logic [9:0]  spr_y_o,
    output logic        edge_hit_o,
    output logic        corner_hit_o,
    output logic [15:0] bounce_cnt_o
);

    localparam logic [9:0] XMAX   = 10'(H_ACTIVE - SPR_W);
    localparam logic [9:0] YMAX   = 10'(V_ACTIVE - SPR_H);
    localparam logic [9:0] STEP_V = 10'(STEP);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    motion_e          state_q;
    logic [DIV_W-1:0] div_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    dir_e             dx_q;
    dir_e             dy_q;
    logic             edge_q;
    logic             corner_q;
    logic [15:0]      cnt_q;

    logic  tick;
    logic  bnc_d;
    axis_t ax_d;
    axis_t ay_d;

    assign tick  = (v_cnt_i == 10'(V_ACTIVE)) && (h_cnt_i == 10'd0);
    assign ax_d  = axis_step(x_q, dx_q, STEP_V, XMAX);
    assign ay_d  = axis_step(y_q, dy_q, STEP_V, YMAX);
    assign bnc_d = ax_d.bounce | ay_d.bounce;

    // RUN/HOLD state, frame divider, position and bounce flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            div_q    <= '0;
            x_q      <= 10'(START_X);
            y_q      <= 10'(START_Y);
            dx_q     <= DIR_POS;
            dy_q     <= DIR_NEG;
            edge_q   <= 1'b0;
            corner_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            edge_q   <= 1'b0;
            corner_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (pause_i) begin
                        state_q <= HOLD;
                    end else if (tick) begin
                        if (div_q == DIV_LAST) begin
                            div_q    <= '0;
                            x_q      <= ax_d.pos;
                            dx_q     <= ax_d.dir;
                            y_q      <= ay_d.pos;
                            dy_q     <= ay_d.dir;
                            edge_q   <= bnc_d;
                            corner_q <= ax_d.bounce & ay_d.bounce;
                            if (bnc_d && (cnt_q != 16'hFFFF)) begin
                                cnt_q <= cnt_q + 16'd1;
                            end
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!pause_i) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign spr_x_o      = x_q;
    assign spr_y_o      = y_q;
    assign edge_hit_o   = edge_q;
    assign corner_hit_o = corner_q;
    assign bounce_cnt_o = cnt_q;

endmodule

// File: rtl/sprite_bounce_engine.sv
// Bouncing-sprite renderer: hit test, ROM addressing and a
// 3-stage pixel pipeline matched to the registered sprite ROM.
module sprite_bounce_engine
    import sprite_pkg::*;
#(
    parameter int   H_ACTIVE    = H_ACTIVE_DEF,
    parameter int   V_ACTIVE    = V_ACTIVE_DEF,
    parameter int   SPR_W       = 100,
    parameter int   SPR_H       = 100,
    parameter int   STEP        = 1,
    parameter int   FRAME_DIV   = 2,
    parameter int   START_X     = 430,
    parameter int   START_Y     = 50,
    parameter bit   TRANSPARENT = 1'b1,
    parameter rgb_t KEY_COLOR   = sprite_pkg::KEY_COLOR,
    parameter int   ADDR_W      = $clog2(SPR_W * SPR_H)
) (
    input logic                   clk,
    input logic                   rst,
    sprite_bounce_engine_if.slave bus
);

    logic [9:0]        spr_x;
    logic [9:0]        spr_y;
    logic              hit;
    logic              keyed;
    logic [31:0]       addr_full;
    logic [ADDR_W-1:0] addr_q;
    logic              val1_q;
    logic              hit1_q;
    logic              val2_q;
    logic              hit2_q;
    rgb_t              vga_q;
    rgb_t              pix_d;

    sprite_motion #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .STEP      (STEP),
        .FRAME_DIV (FRAME_DIV),
        .START_X   (START_X),
        .START_Y   (START_Y)
    ) u_motion (
        .clk          (clk),
        .rst          (rst),
        .h_cnt_i      (bus.h_cnt),
        .v_cnt_i      (bus.v_cnt),
        .pause_i      (bus.pause),
        .spr_x_o      (spr_x),
        .spr_y_o      (spr_y),
        .edge_hit_o   (bus.edge_hit),
        .corner_hit_o (bus.corner_hit),
        .bounce_cnt_o (bus.bounce_cnt)
    );

    assign hit = bus.valid
        && (bus.h_cnt >= spr_x)
        && ({1'b0, bus.h_cnt} <= ({1'b0, spr_x} + 11'(SPR_W - 1)))
        && (bus.v_cnt >= spr_y)
        && ({1'b0, bus.v_cnt} <= ({1'b0, spr_y} + 11'(SPR_H - 1)));

    assign addr_full = 32'(bus.v_cnt - spr_y) * 32'(SPR_W)
                     + 32'(bus.h_cnt - spr_x);

    assign keyed = TRANSPARENT && (bus.rom_data == KEY_COLOR);

    // Final pixel mux; a hit always implies valid, so arms are disjoint.
    always_comb begin
        pix_d = BLACK;
        unique case (1'b1)
            !val2_q:           pix_d = BLACK;
            val2_q && !hit2_q: pix_d = bus.bg_color;
            hit2_q && keyed:   pix_d = bus.bg_color;
            default:           pix_d = bus.rom_data;
        endcase
    end

    // Address stage, flag delay to match ROM latency, pixel register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            val1_q <= 1'b0;
            hit1_q <= 1'b0;
            val2_q <= 1'b0;
            hit2_q <= 1'b0;
            vga_q  <= BLACK;
        end else begin
            val1_q <= bus.valid;
            hit1_q <= hit;
            if (hit) begin
                addr_q <= ADDR_W'(addr_full);
            end
            val2_q <= val1_q;
            hit2_q <= hit1_q;
            vga_q  <= pix_d;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.vga_data = vga_q;
    assign bus.spr_x    = spr_x;
    assign bus.spr_y    = spr_y;

endmodule
